// File: rtl/control_logic_unit_if.sv
// Decode bus between fetch and the control logic unit: opcode in, datapath strobes out.
// CTRL_ILLEGAL_TRAP_EN adds the sticky illegal_op flag to the bus.
interface control_logic_unit_if;
   logic [3:0] opcode;
   logic       data_reg;
   logic       call;
   logic       rtrn;
   logic       branch;
   logic       mem_to_reg;
   logic       reg_to_mem;
   logic [2:0] alu_op;
   logic       alu_src;
   logic       sign_ext_sel;
   logic       reg_rt_src;
   logic       RegWrite;
   logic       half_spec;
`ifdef CTRL_ILLEGAL_TRAP_EN
   logic       illegal_op;
`endif

   modport master (
      output opcode,
      input  data_reg, call, rtrn, branch, mem_to_reg, reg_to_mem,
             alu_op, alu_src, sign_ext_sel, reg_rt_src, RegWrite, half_spec
`ifdef CTRL_ILLEGAL_TRAP_EN
      , input illegal_op
`endif
   );

   modport slave (
      input  opcode,
      output data_reg, call, rtrn, branch, mem_to_reg, reg_to_mem,
             alu_op, alu_src, sign_ext_sel, reg_rt_src, RegWrite, half_spec
`ifdef CTRL_ILLEGAL_TRAP_EN
      , output illegal_op
`endif
   );
endinterface

// File: rtl/control_logic_unit.sv
// Combinational opcode decoder for the 16-bit core; all strobes forced low while rst_n=0.
// CTRL_ILLEGAL_TRAP_EN adds a sticky illegal-opcode flop (the only use of clk).
module control_logic_unit (
   input logic                 clk,
   input logic                 rst_n,
   control_logic_unit_if.slave bus
);

   typedef struct packed {
      logic       data_reg;
      logic       call;
      logic       rtrn;
      logic       branch;
      logic       mem_to_reg;
      logic       reg_to_mem;
      logic [2:0] alu_op;
      logic       alu_src;
      logic       sign_ext_sel;
      logic       reg_rt_src;
      logic       RegWrite;
      logic       half_spec;
   } ctrl_t;

   ctrl_t ctrl;

   // Unknown opcodes fall to default, which is the ERR (all-zero) decode.
   always_comb begin
      ctrl = '0;
      if (rst_n) begin
         case (bus.opcode)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'hA, 4'hC: begin
               ctrl.alu_op = bus.opcode[2:0];
               ctrl.branch = (bus.opcode == 4'hC);
            end
            4'h4: begin
               ctrl.alu_op       = bus.opcode[2:0];
               ctrl.alu_src      = 1'b1;
               ctrl.sign_ext_sel = 1'b1;
            end
            4'h8: begin
               ctrl.alu_op     = bus.opcode[2:0];
               ctrl.data_reg   = 1'b1;
               ctrl.mem_to_reg = 1'b1;
               ctrl.alu_src    = 1'b1;
            end
            4'h9: begin
               ctrl.alu_op     = bus.opcode[2:0];
               ctrl.data_reg   = 1'b1;
               ctrl.reg_to_mem = 1'b1;
               ctrl.alu_src    = 1'b1;
               ctrl.reg_rt_src = 1'b1;
            end
            4'hB: begin
               ctrl.alu_op    = bus.opcode[2:0];
               ctrl.half_spec = 1'b1;
            end
            4'hD: begin
               ctrl.call       = 1'b1;
               ctrl.reg_to_mem = 1'b1;
               ctrl.RegWrite   = 1'b1;
            end
            4'hE: begin
               ctrl.rtrn     = 1'b1;
               ctrl.RegWrite = 1'b1;
            end
            default: ctrl = '0;
         endcase
      end
   end

   assign bus.data_reg     = ctrl.data_reg;
   assign bus.call         = ctrl.call;
   assign bus.rtrn         = ctrl.rtrn;
   assign bus.branch       = ctrl.branch;
   assign bus.mem_to_reg   = ctrl.mem_to_reg;
   assign bus.reg_to_mem   = ctrl.reg_to_mem;
   assign bus.alu_op       = ctrl.alu_op;
   assign bus.alu_src      = ctrl.alu_src;
   assign bus.sign_ext_sel = ctrl.sign_ext_sel;
   assign bus.reg_rt_src   = ctrl.reg_rt_src;
   assign bus.RegWrite     = ctrl.RegWrite;
   assign bus.half_spec    = ctrl.half_spec;

`ifdef CTRL_ILLEGAL_TRAP_EN
   logic illegal_q, illegal_d;

   assign illegal_d = illegal_q | (bus.opcode == 4'hF);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) illegal_q <= 1'b0;
      else        illegal_q <= illegal_d;
   end

   assign bus.illegal_op = illegal_q;
`else
   // clk only matters to the trap; keep it on the port list for uniformity.
   logic unused_clk;
   assign unused_clk = clk;
`endif

endmodule

// File: tb/tb_control_logic_unit.sv
// Directed check of the opcode decode table, async reset gating and the optional trap.
module tb_control_logic_unit;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   control_logic_unit_if bus ();

   control_logic_unit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // {data_reg,call,rtrn,branch, mem_to_reg,reg_to_mem, alu_op, alu_src,sign_ext_sel,reg_rt_src, RegWrite,half_spec}
   logic [13:0] exp_tbl [16];

   function automatic logic [13:0] obs_vec();
      return {bus.data_reg, bus.call, bus.rtrn, bus.branch,
              bus.mem_to_reg, bus.reg_to_mem, bus.alu_op,
              bus.alu_src, bus.sign_ext_sel, bus.reg_rt_src,
              bus.RegWrite, bus.half_spec};
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   initial begin
      exp_tbl[4'h0] = 14'b0000_00_000_000_00;
      exp_tbl[4'h1] = 14'b0000_00_001_000_00;
      exp_tbl[4'h2] = 14'b0000_00_010_000_00;
      exp_tbl[4'h3] = 14'b0000_00_011_000_00;
      exp_tbl[4'h4] = 14'b0000_00_100_110_00;
      exp_tbl[4'h5] = 14'b0000_00_101_000_00;
      exp_tbl[4'h6] = 14'b0000_00_110_000_00;
      exp_tbl[4'h7] = 14'b0000_00_111_000_00;
      exp_tbl[4'h8] = 14'b1000_10_000_100_00;
      exp_tbl[4'h9] = 14'b1000_01_001_101_00;
      exp_tbl[4'hA] = 14'b0000_00_010_000_00;
      exp_tbl[4'hB] = 14'b0000_00_011_000_01;
      exp_tbl[4'hC] = 14'b0001_00_100_000_00;
      exp_tbl[4'hD] = 14'b0100_01_000_000_10;
      exp_tbl[4'hE] = 14'b0010_00_000_000_10;
      exp_tbl[4'hF] = 14'b0000_00_000_000_00;

      // Reset forces everything low even for a live LW opcode.
      bus.opcode = 4'h8;
      #3;
      chk("reset_lw", {2'b0, obs_vec()}, 16'h0000);
`ifdef CTRL_ILLEGAL_TRAP_EN
      chk("reset_trap", {15'b0, bus.illegal_op}, 16'h0000);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("release_lw", {2'b0, obs_vec()}, {2'b0, 14'b1000_10_000_100_00});

      // Full opcode sweep, each sampled 1 ns after the change.
      for (int op = 0; op < 16; op++) begin
         @(negedge clk);
         bus.opcode = 4'(op);
         #1;
         chk($sformatf("op_%h", op), {2'b0, obs_vec()}, {2'b0, exp_tbl[op]});
      end

      // Spot checks on individual fields.
      @(negedge clk); bus.opcode = 4'h4; #1;
      chk("inc_alu_op", {13'b0, bus.alu_op}, 16'h0004);
      @(negedge clk); bus.opcode = 4'hD; #1;
      chk("call_bits", {13'b0, bus.call, bus.reg_to_mem, bus.RegWrite}, 16'h0007);
      @(negedge clk); bus.opcode = 4'hE; #1;
      chk("ret_bits", {14'b0, bus.rtrn, bus.RegWrite}, 16'h0003);
      @(negedge clk); bus.opcode = 4'hB; #1;
      chk("llb_half", {12'b0, bus.half_spec, bus.alu_op}, 16'h000B);

      // Async reset mid-sweep: branch must drop without a clock edge.
      @(negedge clk); bus.opcode = 4'hC; #1;
      chk("b_branch", {15'b0, bus.branch}, 16'h0001);
      #1 rst_n = 1'b0;
      #1;
      chk("b_async_rst", {2'b0, obs_vec()}, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("b_resume", {2'b0, obs_vec()}, {2'b0, exp_tbl[4'hC]});

`ifdef CTRL_ILLEGAL_TRAP_EN
      @(negedge clk); bus.opcode = 4'h0;
      @(negedge clk);
      chk("trap_clear", {15'b0, bus.illegal_op}, 16'h0000);
      bus.opcode = 4'hF;
      @(negedge clk);
      chk("trap_set", {15'b0, bus.illegal_op}, 16'h0001);
      chk("err_zero", {2'b0, obs_vec()}, 16'h0000);
      bus.opcode = 4'h0;
      @(negedge clk);
      @(negedge clk);
      chk("trap_sticky", {15'b0, bus.illegal_op}, 16'h0001);
      rst_n = 1'b0;
      #1;
      chk("trap_rst", {15'b0, bus.illegal_op}, 16'h0000);
      rst_n = 1'b1;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
